// File: rtl/riscv_pkg.sv
// Shared core constants: XLEN, control-transfer kind encodings and the fetch
// sequencer state type.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        TRAP  = 2'd2
    } pc_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational control-transfer target: ex_pc+imm for branch/JAL, and
// (rs1+imm) with bit 0 cleared for JALR. Flags targets not word aligned.
module branch_target_calc
    import riscv_pkg::*;
(
    input  logic [1:0]      ex_kind,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic            w_is_jalr;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_sum;

    assign w_is_jalr  = (ex_kind == KIND_JALR);
    assign w_base     = w_is_jalr ? ex_rs1 : ex_pc;
    // Sum wraps modulo 2^XLEN by construction.
    assign w_sum      = w_base + ex_imm;
    assign target     = w_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    assign misaligned = |target[1:0];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: drives the imem request handshake, redirects on taken
// branch/JAL/JALR and holds flush_o for FLUSH_CYCLES. Optional: MISALIGN_TRAP_EN.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        ex_valid,
    input  logic [1:0]  ex_kind,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        cond_taken,
    output logic [31:0] link_addr,
    output logic        redirect_o,
    output logic [31:0] redirect_target,
    output logic        flush_o
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        trap_o,
    output logic [31:0] trap_addr
`endif
);

    pc_state_t   r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_cnt;
    logic        r_run_q;
    logic        r_redirect;
    logic [31:0] r_redirect_target;
    logic        r_flush;

    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_take;
    logic        w_trap_take;
    logic        w_redirect;
    logic        w_req_valid;

    branch_target_calc u_tgt (
        .ex_kind    (ex_kind),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    // EX inputs during FLUSH belong to squashed instructions, so only RUN accepts.
    assign w_take = ex_valid && (r_state == RUN) &&
                    ((ex_kind == KIND_BRANCH && cond_taken) ||
                     ex_kind == KIND_JAL || ex_kind == KIND_JALR);

`ifdef MISALIGN_TRAP_EN
    logic        r_trap;
    logic [31:0] r_trap_addr;

    assign w_trap_take = w_take && w_misaligned;
    assign trap_o      = r_trap;
    assign trap_addr   = r_trap_addr;
`else
    logic w_unused_misaligned;

    assign w_unused_misaligned = w_misaligned;
    assign w_trap_take         = 1'b0;
`endif

    assign w_redirect  = w_take && !w_trap_take;
    assign w_req_valid = r_run_q && !stall_i && (r_state != TRAP);

    assign imem_req_valid  = w_req_valid;
    assign imem_addr       = r_pc;
    assign link_addr       = ex_pc + 32'd4;
    assign redirect_o      = r_redirect;
    assign redirect_target = r_redirect_target;
    assign flush_o         = r_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state           <= RUN;
            r_pc              <= RESET_PC;
            r_cnt             <= '0;
            r_run_q           <= 1'b0;
            r_redirect        <= 1'b0;
            r_redirect_target <= '0;
            r_flush           <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_trap            <= 1'b0;
            r_trap_addr       <= '0;
`endif
        end else begin
            r_run_q    <= 1'b1;
            r_redirect <= 1'b0;

            // Redirect beats stall and accept; it may abandon an unaccepted request.
            if (w_redirect)
                r_pc <= w_target;
            else if (w_req_valid && imem_req_ready)
                r_pc <= r_pc + 32'd4;

            case (r_state)
                RUN: begin
                    if (w_take) begin
`ifdef MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state     <= TRAP;
                            r_trap      <= 1'b1;
                            r_trap_addr <= w_target;
                        end else
`endif
                        begin
                            r_state           <= FLUSH;
                            r_cnt             <= 3'(FLUSH_CYCLES);
                            r_redirect        <= 1'b1;
                            r_redirect_target <= w_target;
                            r_flush           <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (r_cnt == 3'd1) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: per-cycle expected fetch state is
// queued per scenario and popped at each falling edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        imem_req_ready = 1'b1;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_kind = 2'b00;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic [31:0] ex_rs1 = '0;
    logic        cond_taken = 1'b0;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] link_addr;
    logic        redirect_o;
    logic [31:0] redirect_target;
    logic        flush_o;
`ifdef MISALIGN_TRAP_EN
    logic        trap_o;
    logic [31:0] trap_addr;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
        logic        redir;
        logic        flush;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .ex_valid        (ex_valid),
        .ex_kind         (ex_kind),
        .ex_pc           (ex_pc),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .cond_taken      (cond_taken),
        .link_addr       (link_addr),
        .redirect_o      (redirect_o),
        .redirect_target (redirect_target),
        .flush_o         (flush_o)
`ifdef MISALIGN_TRAP_EN
        ,
        .trap_o          (trap_o),
        .trap_addr       (trap_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle_ex();
        ex_valid   = 1'b0;
        ex_kind    = 2'b00;
        cond_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_ex();
        stall_i        = 1'b0;
        imem_req_ready = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        idle_ex();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got v=%b a=%h r=%b f=%b, want v=0 a=0 r=0 f=0",
                     imem_req_valid, imem_addr, redirect_o, flush_o);
        end
        checks++;
        if (redirect_target !== 32'h0) begin
            failures++;
            $display("FAIL reset_target: got %h want 0", redirect_target);
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_valid: got %b want 0", imem_req_valid);
        end
        sb = {};
        sb.push_back({1'b1, 32'h0, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'h4, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'h8, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'hC, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== e) begin
                failures++;
                $display("FAIL seq cyc%0d: got v=%b a=%h r=%b f=%b want v=%b a=%h r=%b f=%b", i,
                         imem_req_valid, imem_addr, redirect_o, flush_o, e.vld, e.addr, e.redir, e.flush);
            end
        end
    endtask

    task automatic test_branch_taken();
        exp_t e;
        do_reset();
        sb = {};
        sb.push_back({1'b1, 32'h0,  1'b0, 1'b0});
        sb.push_back({1'b1, 32'hF0, 1'b1, 1'b1});
        sb.push_back({1'b1, 32'hF4, 1'b0, 1'b1});
        sb.push_back({1'b1, 32'hF8, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'hFC, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== e) begin
                failures++;
                $display("FAIL branch cyc%0d: got v=%b a=%h r=%b f=%b want v=%b a=%h r=%b f=%b", i,
                         imem_req_valid, imem_addr, redirect_o, flush_o, e.vld, e.addr, e.redir, e.flush);
            end
            case (i)
                0: begin
                    ex_valid = 1'b1; ex_kind = 2'b01; cond_taken = 1'b1;
                    ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
                end
                1: begin
                    // A second take while flushing must be ignored.
                    ex_kind = 2'b10; ex_pc = 32'h200; ex_imm = 32'h40;
                end
                2: idle_ex();
                3: begin
                    checks++;
                    if (redirect_target !== 32'hF0) begin
                        failures++;
                        $display("FAIL branch_target_hold: got %h want 000000f0", redirect_target);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_not_taken_jalr();
        exp_t e;
        do_reset();
        sb = {};
        sb.push_back({1'b1, 32'h0,    1'b0, 1'b0});
        sb.push_back({1'b1, 32'h4,    1'b0, 1'b0});
        sb.push_back({1'b1, 32'h2004, 1'b1, 1'b1});
        sb.push_back({1'b1, 32'h2008, 1'b0, 1'b1});
        sb.push_back({1'b1, 32'h200C, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== e) begin
                failures++;
                $display("FAIL ntjalr cyc%0d: got v=%b a=%h r=%b f=%b want v=%b a=%h r=%b f=%b", i,
                         imem_req_valid, imem_addr, redirect_o, flush_o, e.vld, e.addr, e.redir, e.flush);
            end
            case (i)
                0: begin
                    ex_valid = 1'b1; ex_kind = 2'b01; cond_taken = 1'b0;
                    ex_pc = 32'h40; ex_imm = 32'h100;
                end
                1: begin
                    checks++;
                    if (link_addr !== 32'h44) begin
                        failures++;
                        $display("FAIL link_branch: got %h want 00000044", link_addr);
                    end
                    ex_kind = 2'b11; ex_pc = 32'h300; ex_rs1 = 32'h2001; ex_imm = 32'h4;
                end
                2: begin
                    checks++;
                    if (link_addr !== 32'h304) begin
                        failures++;
                        $display("FAIL link_jalr: got %h want 00000304", link_addr);
                    end
                    checks++;
                    if (redirect_target !== 32'h2004) begin
                        failures++;
                        $display("FAIL jalr_target: got %h want 00002004", redirect_target);
                    end
                    idle_ex();
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_handshake_stall();
        exp_t e;
        do_reset();
        sb = {};
        sb.push_back({1'b1, 32'h0,  1'b0, 1'b0});
        sb.push_back({1'b1, 32'h0,  1'b0, 1'b0});
        sb.push_back({1'b1, 32'h0,  1'b0, 1'b0});
        sb.push_back({1'b1, 32'h0,  1'b0, 1'b0});
        sb.push_back({1'b1, 32'h4,  1'b0, 1'b0});
        sb.push_back({1'b0, 32'h4,  1'b0, 1'b0});
        sb.push_back({1'b0, 32'hA0, 1'b1, 1'b1});
        sb.push_back({1'b1, 32'hA4, 1'b0, 1'b1});
        sb.push_back({1'b1, 32'hA8, 1'b0, 1'b0});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== e) begin
                failures++;
                $display("FAIL hs cyc%0d: got v=%b a=%h r=%b f=%b want v=%b a=%h r=%b f=%b", i,
                         imem_req_valid, imem_addr, redirect_o, flush_o, e.vld, e.addr, e.redir, e.flush);
            end
            case (i)
                0: imem_req_ready = 1'b0;
                3: imem_req_ready = 1'b1;
                4: stall_i = 1'b1;
                5: begin
                    ex_valid = 1'b1; ex_kind = 2'b10; ex_pc = 32'h80; ex_imm = 32'h20;
                end
                6: begin
                    idle_ex();
                    stall_i = 1'b0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_wrap_reset();
        exp_t e;
        do_reset();
        sb = {};
        sb.push_back({1'b1, 32'h0, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'h4, 1'b1, 1'b1});
        sb.push_back({1'b0, 32'h0, 1'b0, 1'b0});
        sb.push_back({1'b1, 32'h0, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({imem_req_valid, imem_addr, redirect_o, flush_o} !== e) begin
                failures++;
                $display("FAIL wrap cyc%0d: got v=%b a=%h r=%b f=%b want v=%b a=%h r=%b f=%b", i,
                         imem_req_valid, imem_addr, redirect_o, flush_o, e.vld, e.addr, e.redir, e.flush);
            end
            case (i)
                0: begin
                    ex_valid = 1'b1; ex_kind = 2'b10; ex_pc = 32'hFFFF_FFFC; ex_imm = 32'h8;
                end
                1: begin
                    checks++;
                    if (link_addr !== 32'h0) begin
                        failures++;
                        $display("FAIL link_wrap: got %h want 00000000", link_addr);
                    end
                    idle_ex();
                    rst_n = 1'b0;
                end
                2: begin
                    checks++;
                    if (redirect_target !== 32'h0) begin
                        failures++;
                        $display("FAIL midflush_reset_target: got %h want 0", redirect_target);
                    end
                    rst_n = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_trap();
        do_reset();
        @(negedge clk);
        ex_valid = 1'b1; ex_kind = 2'b10; ex_pc = 32'h100; ex_imm = 32'h2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_ex();
            checks++;
            if ({imem_req_valid, redirect_o, flush_o, trap_o} !== 4'b0001) begin
                failures++;
                $display("FAIL trap cyc%0d: got v=%b r=%b f=%b t=%b want v=0 r=0 f=0 t=1", i,
                         imem_req_valid, redirect_o, flush_o, trap_o);
            end
            checks++;
            if (trap_addr !== 32'h102) begin
                failures++;
                $display("FAIL trap_addr cyc%0d: got %h want 00000102", i, trap_addr);
            end
        end
        do_reset();
        checks++;
        if ({trap_o, trap_addr} !== 33'h0) begin
            failures++;
            $display("FAIL trap_reset: got t=%b a=%h want 0", trap_o, trap_addr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_branch_taken();
        test_not_taken_jalr();
        test_handshake_stall();
        test_wrap_reset();
`ifdef MISALIGN_TRAP_EN
        test_trap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer end of the branch-condition interface in the core.
- Takes the resolved taken/not-taken bit and the control-transfer info from EX.
- Owns the fetch PC, drives the instruction-memory request handshake, and computes branch/JAL/JALR targets.
- Issues the PC redirect and a timed pipeline flush of the younger IF/ID instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a redirect (legal range 1..7).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- stall_i  in  1  hazard stall; freezes PC advance.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  imem accepts request this cycle.
- imem_addr  out  32  fetch address (current PC).
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_kind  in  2  00 none, 01 cond branch, 10 JAL, 11 JALR.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm  in  32  sign-extended immediate.
- ex_rs1  in  32  rs1 value (JALR base).
- cond_taken  in  1  branch condition result from the condition evaluator.
- link_addr  out  32  ex_pc+4, combinational, for JAL/JALR rd writeback.
- redirect_o  out  1  one-cycle pulse, registered, when PC was redirected.
- redirect_target  out  32  target loaded on the redirect; holds its value until the next redirect.
- flush_o  out  1  squash IF/ID contents.

Behaviour:
- Reset, when rst_n is low at an edge:
  - PC=RESET_PC, state=RUN, flush counter=0.
  - redirect_o=0, redirect_target=0, flush_o=0, run_q=0.
  - imem_req_valid is 0 during reset and the first cycle it is sampled; it goes high in the cycle after rst_n is first sampled high.
  - Reset mid-flush or mid-request aborts everything. No request is pending after reset.
- Arithmetic: all sums are 32-bit modulo 2^32; wrap-around is silent.
  - Branch and JAL target = ex_pc+ex_imm.
  - JALR target = (ex_rs1+ex_imm) & ~32'h1.
- take = ex_valid & accept_ex & ((ex_kind==01 & cond_taken) | ex_kind==10 | ex_kind==11).
  - accept_ex = (state==RUN).
- States:
  - RUN: normal fetch. take -> FLUSH.
  - FLUSH: counter loaded with FLUSH_CYCLES, decrements each cycle; flush_o=1. EX inputs are ignored, since they belong to squashed instructions. Counter reaching 1 -> RUN.
- imem_req_valid = run_q & ~stall_i.
- PC update priority, highest first:
  - (1) take at edge T: PC<=target. redirect_o=1 and flush_o=1 from T+1. imem_addr=target at T+1. Any unaccepted request is abandoned; this is the only permitted address change while valid&~ready.
  - (2) imem_req_valid & imem_req_ready: PC<=PC+4.
  - (3) otherwise PC holds. Address stays stable while valid&~ready.
- Simultaneous take and stall_i: redirect wins, because the EX instruction is older than the stalled one.
- Simultaneous take and imem accept: redirect wins; the accepted word is squashed by flush_o.
- Fetch continues during FLUSH: PC advances from the target, and flush does not block imem requests.
- Back-to-back redirects are impossible: a take is accepted at most once per FLUSH_CYCLES+1 cycles.
- Misaligned target (target[1:0]!=0) is loaded as-is, with no check, unless the optional feature is enabled.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds outputs trap_o (1) and trap_addr (32), and state TRAP.
  - A take whose target[1:0]!=0 does not redirect. Instead, on the next cycle: trap_o=1 (level), trap_addr=target, state=TRAP.
  - TRAP forces imem_req_valid=0 and freezes PC. It exits only via rst_n.
  - trap_o and trap_addr reset to 0.
- Undefined: no trap ports and no TRAP state. A misaligned target is loaded as-is.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN=32.
  - KIND_NONE/KIND_BRANCH/KIND_JAL/KIND_JALR 2-bit constants.
  - pc_state_t enum {RUN, FLUSH, TRAP}.
- One combinational sub-module, branch_target_calc: inputs ex_kind, ex_pc, ex_imm, ex_rs1; outputs target and misaligned.
- The FSM, counter and PC register stay in pc_sequencer.

Test Plan:
- Reset then release, ready=1: imem_addr sequence 0x0,0x4,0x8,0xC; valid low until the cycle after release.
- Branch taken: ex_kind=01, cond_taken=1, ex_pc=0x100, ex_imm=0xFFFFFFF0 -> next cycle imem_addr=0xF0, redirect_o pulse, flush_o high exactly 2 cycles; a second take during those cycles is ignored.
- Branch not taken (cond_taken=0) and JALR with ex_rs1=0x2001, ex_imm=0x4: not-taken gives no redirect and PC keeps +4; JALR gives target 0x2004, link_addr=ex_pc+4.
- Handshake hold: ready=0 for 3 cycles -> imem_addr stable; stall_i=1 drops valid; take with stall_i=1 still redirects.
- Wrap and reset: ex_pc=0xFFFFFFFC, JAL imm=0x8 -> target 0x4; assert rst_n low during FLUSH -> flush_o=0, PC=RESET_PC next cycle.
- With MISALIGN_TRAP_EN: JAL target 0x102 -> no redirect, trap_o=1, trap_addr=0x102, valid held low until reset.
